// File: rtl/lstm_dx_engine.sv
// lstm_dx_engine: sequences (j,k) reads of the four gate-delta and weight memories and
// accumulates dX[j] = sum_k sum_g d_g[k]*W_g[k][j], writing one saturated word per j.
module lstm_dx_engine #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 24,
  parameter int N_CELL = 8,
  parameter int N_OUT  = 53,
  parameter int ADDR_G = 6,
  parameter int ADDR_W = 9,
  parameter int ADDR_O = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_G-1:0] gate_base,
  input  logic [ADDR_O-1:0] out_base,
  output logic [ADDR_G-1:0] o_rd_addr_g,
  output logic [ADDR_W-1:0] o_rd_addr_w,
  input  logic [WIDTH-1:0]  i_da,
  input  logic [WIDTH-1:0]  i_di,
  input  logic [WIDTH-1:0]  i_df,
  input  logic [WIDTH-1:0]  i_do,
  input  logic [WIDTH-1:0]  i_wa,
  input  logic [WIDTH-1:0]  i_wi,
  input  logic [WIDTH-1:0]  i_wf,
  input  logic [WIDTH-1:0]  i_wo,
  output logic              o_wr,
  output logic [ADDR_O-1:0] o_wr_addr,
  output logic [WIDTH-1:0]  o_data,
  output logic              busy,
  output logic              done
);

  localparam int ACCW = WIDTH + 8;
  localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int KW   = (N_CELL > 1) ? $clog2(N_CELL) : 1;
  localparam logic [JW-1:0]     J_LAST   = JW'(N_OUT - 1);
  localparam logic [KW-1:0]     K_LAST   = KW'(N_CELL - 1);
  localparam logic [ADDR_W-1:0] W_STRIDE = ADDR_W'(N_OUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // Full-precision product, floor-shifted back to the fixed-point scale, kept at accumulator width.
  function automatic logic signed [ACCW-1:0] f_term(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = a * b;
    return ACCW'(p >>> FRAC);
  endfunction

  function automatic logic [WIDTH-1:0] f_sat(input logic signed [ACCW-1:0] v);
    logic [WIDTH-1:0] res;
    if ((&v[ACCW-1:WIDTH-1]) || (~|v[ACCW-1:WIDTH-1])) begin
      res = v[WIDTH-1:0];
    end else if (v[ACCW-1]) begin
      res = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      res = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return res;
  endfunction

  state_t                  r_state;
  logic [JW-1:0]           r_j;
  logic [KW-1:0]           r_k;
  logic [ADDR_G-1:0]       r_gate_base;
  logic [ADDR_G-1:0]       r_rd_addr_g;
  logic [ADDR_W-1:0]       r_rd_addr_w;
  logic [ADDR_O-1:0]       r_out_base;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_d_valid;
  logic                    r_d_first;
  logic                    r_d_last;
  logic [JW-1:0]           r_d_j;
  logic signed [ACCW-1:0]  r_acc;
  logic                    r_wr;
  logic [ADDR_O-1:0]       r_wr_addr;
  logic [WIDTH-1:0]        r_data;
  logic                    w_last_k;
  logic                    w_last_j;
  logic signed [ACCW-1:0]  w_sum;
  logic signed [ACCW-1:0]  w_acc_next;

  assign w_last_k = (r_k == K_LAST);
  assign w_last_j = (r_j == J_LAST);

  // Sum of the four gate products for the pair whose data is on the read ports this cycle.
  always_comb begin
    w_sum = f_term(i_da, i_wa) + f_term(i_di, i_wi) + f_term(i_df, i_wf) + f_term(i_do, i_wo);
    if (r_d_first) begin
      w_acc_next = w_sum;
    end else begin
      w_acc_next = r_acc + w_sum;
    end
  end

  // Pass FSM and address issue; the weight address steps by N_OUT per k and restarts at j+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_j         <= {JW{1'b0}};
      r_k         <= {KW{1'b0}};
      r_gate_base <= {ADDR_G{1'b0}};
      r_out_base  <= {ADDR_O{1'b0}};
      r_rd_addr_g <= {ADDR_G{1'b0}};
      r_rd_addr_w <= {ADDR_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_j         <= {JW{1'b0}};
            r_k         <= {KW{1'b0}};
            r_gate_base <= gate_base;
            r_out_base  <= out_base;
            r_rd_addr_g <= gate_base;
            r_rd_addr_w <= {ADDR_W{1'b0}};
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_last_k && w_last_j) begin
            r_state <= S_DRAIN;
          end else if (w_last_k) begin
            r_k         <= {KW{1'b0}};
            r_j         <= r_j + JW'(1);
            r_rd_addr_g <= r_gate_base;
            r_rd_addr_w <= ADDR_W'(r_j) + ADDR_W'(1);
          end else begin
            r_k         <= r_k + KW'(1);
            r_rd_addr_g <= r_rd_addr_g + ADDR_G'(1);
            r_rd_addr_w <= r_rd_addr_w + W_STRIDE;
          end
        end
        S_DRAIN: begin
          r_state <= S_FLUSH;
          r_done  <= 1'b1;
        end
        S_FLUSH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Data stage: tags follow the issued pair by one cycle to meet the read data, then MAC and write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_valid <= 1'b0;
      r_d_first <= 1'b0;
      r_d_last  <= 1'b0;
      r_d_j     <= {JW{1'b0}};
      r_acc     <= {ACCW{1'b0}};
      r_wr      <= 1'b0;
      r_wr_addr <= {ADDR_O{1'b0}};
      r_data    <= {WIDTH{1'b0}};
    end else begin
      r_d_valid <= (r_state == S_RUN);
      r_d_first <= (r_k == {KW{1'b0}});
      r_d_last  <= w_last_k;
      r_d_j     <= r_j;
      r_wr      <= r_d_valid && r_d_last;
      if (r_d_valid) begin
        r_acc <= w_acc_next;
      end else begin
        r_acc <= r_acc;
      end
      if (r_d_valid && r_d_last) begin
        r_data    <= f_sat(w_acc_next);
        r_wr_addr <= r_out_base + ADDR_O'(r_d_j);
      end else begin
        r_data    <= r_data;
        r_wr_addr <= r_wr_addr;
      end
    end
  end

  assign o_rd_addr_g = r_rd_addr_g;
  assign o_rd_addr_w = r_rd_addr_w;
  assign o_wr        = r_wr;
  assign o_wr_addr   = r_wr_addr;
  assign o_data      = r_data;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: doc/lstm_dx_engine.md
Name: lstm_dx_engine

Overview:
- Fills the gate-to-output stage of the LSTM backprop datapath: the gate-delta multiplexer, weight multiplexer and MAC sequencing.
- Reads the stored dA/dI/dF/dO gate deltas of one timestep together with the matching W (or U) weights.
- Computes dX[j] = sum over k, over gates g of d_g[k]*W_g[k][j] for every output index j, and streams each result to a dX or delta-out memory write port.
- Sits downstream of the per-layer delta unit and its gate-delta memories, and upstream of the dX / delta-out memories.

Parameters:
WIDTH, 32, signed fixed-point word width
FRAC, 24, fractional bits
N_CELL, 8, cells k per timestep (inner loop length)
N_OUT, 53, output indices j (outer loop length)
ADDR_G, 6, gate-memory address width
ADDR_W, 9, weight-memory address width
ADDR_O, 9, result-memory address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin one pass; sampled only in IDLE
gate_base  in  ADDR_G  gate-memory address of k=0, latched at start
out_base  in  ADDR_O  result address of j=0, latched at start
o_rd_addr_g  out  ADDR_G  shared read address to the four gate memories
o_rd_addr_w  out  ADDR_W  shared read address to the four weight memories
i_da, i_di, i_df, i_do  in  WIDTH each  gate-delta read data, 1-cycle read latency
i_wa, i_wi, i_wf, i_wo  in  WIDTH each  weight read data, 1-cycle read latency
o_wr  out  1  result write strobe
o_wr_addr  out  ADDR_O  result address
o_data  out  WIDTH  saturated result
busy  out  1  pass in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; counters and accumulator cleared.
  - Reset mid-pass aborts immediately: no further o_wr, and no done for the aborted pass.
- States and transitions:
  - IDLE -> RUN when start=1.
  - RUN issues one (j,k) pair per cycle: k inner 0..N_CELL-1, j outer 0..N_OUT-1.
  - RUN -> DRAIN after issuing (N_OUT-1, N_CELL-1).
  - DRAIN -> FLUSH -> IDLE.
- start is ignored while busy; no queuing.
- Addresses (registered outputs):
  - Start sampled in cycle 0; first address pair is driven in cycle 1.
  - o_rd_addr_g = gate_base+k.
  - o_rd_addr_w = k*N_OUT+j, generated by incrementer (no multiplier); modulo 2^ADDR_W.
  - o_wr_addr = out_base+j; wraps modulo 2^ADDR_O.
- Datapath: data for the pair issued in cycle c is consumed in cycle c+1.
  - Four products formed in parallel, each full 2*WIDTH, arithmetic shift right by FRAC (floor), truncated to WIDTH+8 bits.
  - The four products are summed into the accumulator, which is WIDTH+8 bits signed.
  - The accumulator is cleared (overwritten) on each k=0 term.
- Result write:
  - The term for k=N_CELL-1 is added at the end of its data cycle.
  - In the next cycle o_wr=1 for exactly one cycle, with o_data = the final sum saturated to the WIDTH range [0x80000000, 0x7FFFFFFF] for WIDTH=32.
  - o_data holds its value when o_wr=0.
- Latency and throughput:
  - The write for j occurs in cycle j*N_CELL+N_CELL+2.
  - The final write occurs in cycle N_OUT*N_CELL+2.
  - Throughput is one k per cycle, with no bubbles between consecutive j.
- busy is 1 from cycle 1 through the final write cycle inclusive.
- done=1 only in the final write cycle, coincident with the last o_wr.
- A new start is accepted in the cycle after done.
- N_CELL=1 must work: a write every cycle, from cycle 3 to cycle N_OUT+2.

Test Plan:
- N_CELL=2, N_OUT=3, bases 0, all gates 0x01000000 (1.0), all weights 0x00800000 (0.5), start in cycle 0 -> three writes, addresses 0,1,2, in cycles 4,6,8, each o_data=0x04000000; done only in cycle 8; busy cycles 1-8.
- Weights 0x64000000 (100.0), gates 0x64000000 -> o_data=0x7FFFFFFF; with gates negated -> 0x80000000.
- One gate 0xFFFFFFFF (-2^-24), its weight 0x00800000, all else 0 -> o_data=0xFFFFFFFF (floor rounding).
- Address sequencing: gate_base=5, out_base=510 (ADDR_O=9), N_OUT=3, N_CELL=2 -> o_rd_addr_g toggles 5,6; o_rd_addr_w sequence 0,3,1,4,2,5; o_wr_addr 510,511,0.
- Start pulsed again in cycles 3 and 8 -> both ignored; start in cycle 9 -> second pass begins, first address in cycle 10.
- rst asserted in cycle 5 of a pass -> from cycle 6 all outputs 0, no write in cycle 6 or 8, no done; a new start then produces correct results.
